// File: rtl/vpu_wb_pkg.sv
// Shared definitions for the VPU writeback stage: sizes, write-type encodings
// and the stage FSM states.
package vpu_wb_pkg;

    localparam int VREG_NUM = 8;
    localparam int LANES    = 8;
    localparam int LANE_W   = 16;

    localparam logic [1:0] WT_NONE = 2'b00;
    localparam logic [1:0] WT_VEC  = 2'b01;
    localparam logic [1:0] WT_INT  = 2'b10;
    localparam logic [1:0] WT_FP   = 2'b11;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_VEC   = 2'b01,
        ST_SCAL  = 2'b10
    } stage_state_e;

endpackage

// File: rtl/vpu_lane_merge.sv
// Per-lane select between the current register value and new result data.
// One instance feeds both the VRF write and the read-port bypass.
module vpu_lane_merge #(
    parameter int LANES  = vpu_wb_pkg::LANES,
    parameter int LANE_W = vpu_wb_pkg::LANE_W
) (
    input  logic [LANES*LANE_W-1:0] old_v,
    input  logic [LANES*LANE_W-1:0] new_v,
    input  logic [LANES-1:0]        mask,
    output logic [LANES*LANE_W-1:0] merged
);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign merged[i*LANE_W +: LANE_W] = mask[i] ? new_v[i*LANE_W +: LANE_W]
                                                    : old_v[i*LANE_W +: LANE_W];
    end

endmodule

// File: rtl/vpu_wb.sv
// VPU writeback stage: single result register, vector register file with
// bypassed read ports, scalar write-out handshake and busy scoreboard.
//
// state    | meaning
// ST_EMPTY | stage register holds nothing
// ST_VEC   | vector/none result held; commits at the next edge
// ST_SCAL  | scalar result offered on s_wr_*; waits for s_wr_ready
module vpu_wb #(
    parameter int  VREG_NUM = vpu_wb_pkg::VREG_NUM,
    parameter int  LANES    = vpu_wb_pkg::LANES,
    localparam int VW       = LANES * vpu_wb_pkg::LANE_W,
    localparam int IW       = $clog2(VREG_NUM)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [VW-1:0]       in_vd,
    input  logic [31:0]         in_rd,
    input  logic [31:0]         in_fd,
    input  logic [LANES-1:0]    in_mask,
    input  logic [1:0]          in_wtype,
    input  logic [IW-1:0]       in_vdst,
    input  logic [4:0]          in_sdst,
    input  logic [IW-1:0]       vs1_idx,
    input  logic [IW-1:0]       vs2_idx,
    output logic [VW-1:0]       vs1,
    output logic [VW-1:0]       vs2,
    output logic                s_wr_valid,
    input  logic                s_wr_ready,
    output logic                s_wr_fp,
    output logic [4:0]          s_wr_idx,
    output logic [31:0]         s_wr_data,
    input  logic                issue_valid,
    input  logic [IW-1:0]       issue_vdst,
    output logic [VREG_NUM-1:0] vbusy
);

    import vpu_wb_pkg::*;

    typedef struct packed {
        logic [VW-1:0]    vd;
        logic [31:0]      rd;
        logic [31:0]      fd;
        logic [LANES-1:0] mask;
        logic [1:0]       wtype;
        logic [IW-1:0]    vdst;
        logic [4:0]       sdst;
    } stage_t;

    stage_state_e         state_q, state_d;
    stage_t               stage_q, stage_d;
    logic [VW-1:0]        vrf_q [VREG_NUM];
    logic [VW-1:0]        vrf_d [VREG_NUM];
    logic [VREG_NUM-1:0]  vbusy_q, vbusy_d;
    logic [VW-1:0]        merged;
    logic                 vec_commit;
    logic                 scal_done;
    logic                 xfer;

    vpu_lane_merge #(.LANES(LANES), .LANE_W(LANE_W)) u_merge (
        .old_v  (vrf_q[stage_q.vdst]),
        .new_v  (stage_q.vd),
        .mask   (stage_q.mask),
        .merged (merged)
    );

    assign vec_commit = (state_q == ST_VEC) && (stage_q.wtype == WT_VEC);
    assign scal_done  = (state_q == ST_SCAL) && s_wr_ready;
    // Gated by rst so the stage never looks ready while held in reset.
    assign in_ready   = !rst && ((state_q == ST_EMPTY) || (state_q == ST_VEC) || scal_done);
    assign xfer       = in_valid && in_ready;
    assign vbusy      = vbusy_q;

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        if ((state_q == ST_VEC) || scal_done) begin
            state_d = ST_EMPTY;
        end
        if (xfer) begin
            state_d       = in_wtype[1] ? ST_SCAL : ST_VEC;
            stage_d.vd    = in_vd;
            stage_d.rd    = in_rd;
            stage_d.fd    = in_fd;
            stage_d.mask  = in_mask;
            stage_d.wtype = in_wtype;
            stage_d.vdst  = in_vdst;
            stage_d.sdst  = in_sdst;
        end
    end

    always_comb begin
        vrf_d = vrf_q;
        if (vec_commit) begin
            vrf_d[stage_q.vdst] = merged;
        end
    end

    // Set is applied after clear so a same-edge issue keeps the register busy.
    always_comb begin
        vbusy_d = vbusy_q;
        if (vec_commit) begin
            vbusy_d[stage_q.vdst] = 1'b0;
        end
        if (issue_valid) begin
            vbusy_d[issue_vdst] = 1'b1;
        end
    end

    always_comb begin
        vs1 = vrf_q[vs1_idx];
        vs2 = vrf_q[vs2_idx];
        if (vec_commit && (vs1_idx == stage_q.vdst)) begin
            vs1 = merged;
        end
        if (vec_commit && (vs2_idx == stage_q.vdst)) begin
            vs2 = merged;
        end
    end

    always_comb begin
        s_wr_valid = (state_q == ST_SCAL);
        s_wr_fp    = 1'b0;
        s_wr_idx   = '0;
        s_wr_data  = '0;
        if (s_wr_valid) begin
            s_wr_fp   = (stage_q.wtype == WT_FP);
            s_wr_idx  = stage_q.sdst;
            s_wr_data = (stage_q.wtype == WT_FP) ? stage_q.fd : stage_q.rd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            stage_q <= '0;
            vbusy_q <= '0;
            for (int i = 0; i < VREG_NUM; i++) begin
                vrf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            vbusy_q <= vbusy_d;
            vrf_q   <= vrf_d;
        end
    end

endmodule

// File: tb/tb_vpu_wb.sv
// Bench for vpu_wb: directed scenarios plus random traffic, checked every
// cycle against a transaction-level model of the register file and scoreboard.
module tb_vpu_wb;

    import vpu_wb_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_vd;
    logic [31:0]  in_rd;
    logic [31:0]  in_fd;
    logic [7:0]   in_mask;
    logic [1:0]   in_wtype;
    logic [2:0]   in_vdst;
    logic [4:0]   in_sdst;
    logic [2:0]   vs1_idx;
    logic [2:0]   vs2_idx;
    logic [127:0] vs1;
    logic [127:0] vs2;
    logic         s_wr_valid;
    logic         s_wr_ready;
    logic         s_wr_fp;
    logic [4:0]   s_wr_idx;
    logic [31:0]  s_wr_data;
    logic         issue_valid;
    logic [2:0]   issue_vdst;
    logic [7:0]   vbusy;

    always #5 clk = ~clk;

    vpu_wb dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_vd       (in_vd),
        .in_rd       (in_rd),
        .in_fd       (in_fd),
        .in_mask     (in_mask),
        .in_wtype    (in_wtype),
        .in_vdst     (in_vdst),
        .in_sdst     (in_sdst),
        .vs1_idx     (vs1_idx),
        .vs2_idx     (vs2_idx),
        .vs1         (vs1),
        .vs2         (vs2),
        .s_wr_valid  (s_wr_valid),
        .s_wr_ready  (s_wr_ready),
        .s_wr_fp     (s_wr_fp),
        .s_wr_idx    (s_wr_idx),
        .s_wr_data   (s_wr_data),
        .issue_valid (issue_valid),
        .issue_vdst  (issue_vdst),
        .vbusy       (vbusy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Model: register contents, busy bits, the vector result awaiting commit
    // and the scalar result awaiting the register-file port.
    logic [127:0] m_vrf [8];
    logic [7:0]   m_busy;
    bit           pv_valid;
    logic [1:0]   pv_wtype;
    logic [2:0]   pv_idx;
    logic [127:0] pv_data;
    logic [7:0]   pv_mask;
    bit           sp;
    bit           sp_fp;
    logic [4:0]   sp_idx;
    logic [31:0]  sp_data;
    bit           acc;
    int           scal_seen = 0;

    function automatic logic [127:0] lane_mix(input logic [127:0] old_v, input logic [127:0] new_v,
                                              input logic [7:0] mask);
        logic [127:0] r;
        r = old_v;
        for (int l = 0; l < 8; l++) begin
            if (mask[l]) r[l*16 +: 16] = new_v[l*16 +: 16];
        end
        return r;
    endfunction

    function automatic logic [127:0] exp_read(input logic [2:0] idx);
        if (pv_valid && pv_wtype == WT_VEC && pv_idx == idx)
            return lane_mix(m_vrf[idx], pv_data, pv_mask);
        return m_vrf[idx];
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 8; r++) m_vrf[r] = '0;
        m_busy   = '0;
        pv_valid = 0;
        sp       = 0;
    endtask

    // Called just after a falling edge with inputs already driven; checks the
    // outputs, advances the model over the next rising edge, returns at the
    // following falling edge.
    task automatic step();
        bit exp_ready;
        #1;
        if (rst) model_reset();
        exp_ready = !rst && (!sp || s_wr_ready);
        chk("in_ready", in_ready, exp_ready);
        chk("s_wr_valid", s_wr_valid, sp);
        if (sp) begin
            chk("s_wr_fp", s_wr_fp, sp_fp);
            chk("s_wr_idx", s_wr_idx, sp_idx);
            chk("s_wr_data", s_wr_data, sp_data);
        end
        if (s_wr_valid && s_wr_ready) scal_seen++;
        chk("vbusy", vbusy, m_busy);
        chk("vs1", vs1, exp_read(vs1_idx));
        chk("vs2", vs2, exp_read(vs2_idx));
        acc = exp_ready && in_valid;
        if (!rst) begin
            if (pv_valid && pv_wtype == WT_VEC) begin
                m_vrf[pv_idx]  = lane_mix(m_vrf[pv_idx], pv_data, pv_mask);
                m_busy[pv_idx] = 1'b0;
            end
            if (issue_valid) m_busy[issue_vdst] = 1'b1;
            if (sp && s_wr_ready) sp = 0;
            pv_valid = 0;
            if (acc) begin
                if (in_wtype[1]) begin
                    sp      = 1;
                    sp_fp   = in_wtype[0];
                    sp_idx  = in_sdst;
                    sp_data = in_wtype[0] ? in_fd : in_rd;
                end else begin
                    pv_valid = 1;
                    pv_wtype = in_wtype;
                    pv_idx   = in_vdst;
                    pv_data  = in_vd;
                    pv_mask  = in_mask;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_vec(input logic [2:0] vdst, input logic [127:0] vd,
                            input logic [7:0] mask, input logic [1:0] wtype);
        in_valid = 1'b1;
        in_vdst  = vdst;
        in_vd    = vd;
        in_mask  = mask;
        in_wtype = wtype;
        for (int n = 0; n < 20; n++) begin
            step();
            if (acc) break;
        end
        chk("accept", acc, 1'b1);
        in_valid = 1'b0;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [127:0] b2b [8];
    logic [127:0] keep;
    int           seen0;

    initial begin
        rst = 1'b1; in_valid = 0; in_vd = '0; in_rd = '0; in_fd = '0; in_mask = '0;
        in_wtype = WT_NONE; in_vdst = '0; in_sdst = '0; vs1_idx = '0; vs2_idx = '0;
        s_wr_ready = 1'b1; issue_valid = 0; issue_vdst = '0;
        model_reset();
        @(negedge clk);
        step();
        step();
        rst = 1'b0;
        step();

        // Vector write with bypass visibility and busy clear
        issue_valid = 1; issue_vdst = 3'd2;
        step();
        issue_valid = 0;
        vs1_idx = 3'd2;
        send_vec(3'd2, 128'h0001_0002_0003_0004_0005_0006_0007_0008, 8'hFF, WT_VEC);
        #1;
        chk("bypass_vs1", vs1, 128'h0001_0002_0003_0004_0005_0006_0007_0008);
        chk("busy2_pending", vbusy[2], 1'b1);
        step();
        step();
        #1;
        chk("vs1_after", vs1, 128'h0001_0002_0003_0004_0005_0006_0007_0008);
        chk("busy2_clear", vbusy[2], 1'b0);

        // Partial-mask merge
        send_vec(3'd3, {8{16'hAAAA}}, 8'hFF, WT_VEC);
        send_vec(3'd3, {8{16'h5555}}, 8'h0F, WT_VEC);
        step();
        vs2_idx = 3'd3;
        #1;
        chk("mask_merge", vs2, {{4{16'hAAAA}}, {4{16'h5555}}});
        step();

        // Float scalar held off by s_wr_ready
        s_wr_ready = 0;
        in_wtype = WT_FP; in_fd = 32'h3F80_0000; in_rd = $urandom; in_sdst = 5'd7; in_valid = 1;
        step();
        in_valid = 0;
        seen0 = scal_seen;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("scal_hold_valid", s_wr_valid, 1'b1);
            chk("scal_hold_data", s_wr_data, 32'h3F80_0000);
            chk("scal_hold_ready", in_ready, 1'b0);
            step();
        end
        s_wr_ready = 1;
        step();
        step();
        step();
        chk("scal_once", scal_seen - seen0, 1);

        // Same-edge set and clear on reg 4
        send_vec(3'd4, rand128(), 8'hFF, WT_VEC);
        issue_valid = 1; issue_vdst = 3'd4;
        step();
        issue_valid = 0;
        #1;
        chk("set_wins", vbusy[4], 1'b1);
        step();

        // Empty mask clears busy without writing; wtype none keeps busy
        issue_valid = 1; issue_vdst = 3'd5;
        step();
        issue_valid = 0;
        vs1_idx = 3'd5;
        keep = m_vrf[5];
        send_vec(3'd5, rand128(), 8'h00, WT_VEC);
        step();
        #1;
        chk("mask0_busy", vbusy[5], 1'b0);
        chk("mask0_data", vs1, keep);
        issue_valid = 1; issue_vdst = 3'd6;
        step();
        issue_valid = 0;
        vs1_idx = 3'd6;
        keep = m_vrf[6];
        send_vec(3'd6, rand128(), 8'hFF, WT_NONE);
        step();
        #1;
        chk("none_busy", vbusy[6], 1'b1);
        chk("none_data", vs1, keep);
        step();

        // Eight back-to-back vector writes
        in_valid = 1; in_wtype = WT_VEC; in_mask = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            b2b[i]  = rand128();
            in_vdst = 3'(i);
            in_vd   = b2b[i];
            #1;
            chk("b2b_ready", in_ready, 1'b1);
            step();
        end
        in_valid = 0;
        step();
        for (int i = 0; i < 8; i++) begin
            vs1_idx = 3'(i);
            #1;
            chk("b2b_reg", vs1, b2b[i]);
            step();
        end

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            in_valid    = ($urandom_range(0, 2) != 0);
            in_wtype    = 2'($urandom);
            in_vd       = rand128();
            in_rd       = $urandom;
            in_fd       = $urandom;
            in_mask     = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            in_vdst     = 3'($urandom);
            in_sdst     = 5'($urandom);
            s_wr_ready  = ($urandom_range(0, 3) != 0);
            issue_valid = ($urandom_range(0, 3) == 0);
            issue_vdst  = 3'($urandom);
            vs1_idx     = 3'($urandom);
            vs2_idx     = 3'($urandom);
            step();
        end

        // Reset while a scalar write is pending
        in_valid = 0; issue_valid = 0; s_wr_ready = 0;
        step();
        step();
        in_wtype = WT_INT; in_rd = $urandom; in_sdst = 5'd9; in_valid = 1;
        step();
        in_valid = 0;
        step();
        rst = 1;
        #1;
        chk("rst_s_wr_valid", s_wr_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        step();
        rst = 0;
        #1;
        chk("post_rst_ready", in_ready, 1'b1);
        for (int i = 0; i < 8; i++) begin
            vs1_idx = 3'(i);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
